// File: rtl/keccak_pkg.sv
// Shared constants for the Keccak message transmitter: mode encodings, rates,
// header field layout and FSM state encodings.
package keccak_pkg;

    localparam int w = 64;

    localparam logic [1:0] MODE_SHAKE128 = 2'b00;
    localparam logic [1:0] MODE_SHAKE256 = 2'b10;

    localparam logic [4:0] RATE_WORDS_SHAKE128 = 5'd21;
    localparam logic [4:0] RATE_WORDS_SHAKE256 = 5'd17;

    // Header layout: {mode[63:62], out_len[61:32], in_len[31:0]}
    localparam int HDR_IN_LEN_LSB  = 0;
    localparam int HDR_OUT_LEN_LSB = 32;
    localparam int HDR_MODE_LSB    = 62;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_MSG  = 2'd2;
    localparam logic [1:0] ST_PAD  = 2'd3;

    // Anything that is not SHAKE128 falls back to the SHAKE256 rate.
    function automatic logic [4:0] rate_words(input logic [1:0] mode);
        return (mode == MODE_SHAKE128) ? RATE_WORDS_SHAKE128 : RATE_WORDS_SHAKE256;
    endfunction

endpackage

// File: rtl/keccak_msg_tx.sv
// Frames a command header, message words and zero padding into a beat stream
// for the Keccak core. Optional invalid-mode rejection: define KECCAK_TX_ERR_EN.
module keccak_msg_tx
    import keccak_pkg::*;
#(
    parameter int W = w
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [1:0]   cmd_mode,
    input  logic [29:0]  cmd_out_len,
    input  logic [31:0]  cmd_in_len,
    input  logic         msg_valid_i,
    output logic         msg_ready_o,
    input  logic [W-1:0] msg_data,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_out,
    output logic         done_o,
    output logic         err_o
);

    logic [1:0]   state_reg;
    logic         started_reg;
    logic [4:0]   rate_reg;
    logic [25:0]  q_reg;
    logic [5:0]   rem_reg;
    logic [31:0]  msg_words_reg;
    logic [31:0]  word_cnt_reg;
    logic [4:0]   blk_pos_reg;
    logic         last_loaded_reg;
    logic [W-1:0] data_reg;
    logic         valid_reg;
    logic         done_reg;
    logic         err_reg;

    logic         out_free;
    logic         xfer;
    logic         msg_take;
    logic         pad_load;
    logic         data_load;
    logic         blk_last;
    logic         final_word;
    logic         last_msg;
    logic         mode_bad;
    logic [W-1:0] msg_mask;
    logic [W-1:0] header;

`ifdef KECCAK_TX_ERR_EN
    assign mode_bad = (cmd_mode != MODE_SHAKE128) && (cmd_mode != MODE_SHAKE256);
`else
    assign mode_bad = 1'b0;
`endif

    always_comb begin
        header = '0;
        header[HDR_IN_LEN_LSB +: 32]  = cmd_in_len;
        header[HDR_OUT_LEN_LSB +: 30] = cmd_out_len;
        header[HDR_MODE_LSB +: 2]     = cmd_mode;
    end

    assign out_free    = !valid_reg || ready_i;
    assign xfer        = valid_reg && ready_i;
    assign cmd_ready_o = (state_reg == ST_IDLE) && started_reg;
    assign msg_ready_o = (state_reg == ST_MSG) && !last_loaded_reg && out_free;
    assign msg_take    = msg_ready_o && msg_valid_i;
    assign pad_load    = (state_reg == ST_PAD) && !last_loaded_reg && out_free;
    assign data_load   = msg_take || pad_load;

    // The frame ends on the first block boundary strictly past the full-word
    // count, which equals RATE_WORDS x (floor(in_len/rate_bits) + 1).
    assign blk_last   = (blk_pos_reg == rate_reg - 5'd1);
    assign final_word = blk_last && (word_cnt_reg >= {6'd0, q_reg});
    assign last_msg   = (word_cnt_reg + 32'd1 == msg_words_reg);
    assign msg_mask   = (rem_reg == 6'd0) ? '1 : ~({W{1'b1}} >> rem_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            started_reg     <= 1'b0;
            rate_reg        <= '0;
            q_reg           <= '0;
            rem_reg         <= '0;
            msg_words_reg   <= '0;
            word_cnt_reg    <= '0;
            blk_pos_reg     <= '0;
            last_loaded_reg <= 1'b0;
            data_reg        <= '0;
            valid_reg       <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            started_reg <= 1'b1;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        if (mode_bad) begin
                            err_reg <= 1'b1;
                        end else begin
                            rate_reg        <= rate_words(cmd_mode);
                            q_reg           <= cmd_in_len[31:6];
                            rem_reg         <= cmd_in_len[5:0];
                            msg_words_reg   <= {6'd0, cmd_in_len[31:6]} + {31'd0, |cmd_in_len[5:0]};
                            word_cnt_reg    <= '0;
                            blk_pos_reg     <= '0;
                            last_loaded_reg <= 1'b0;
                            data_reg        <= header;
                            valid_reg       <= 1'b1;
                            state_reg       <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (ready_i) begin
                        valid_reg <= 1'b0;
                        state_reg <= (msg_words_reg == 32'd0) ? ST_PAD : ST_MSG;
                    end
                end
                ST_MSG, ST_PAD: begin
                    if (last_loaded_reg && xfer) begin
                        valid_reg <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else if (data_load) begin
                        if (msg_take)
                            data_reg <= last_msg ? (msg_data & msg_mask) : msg_data;
                        else
                            data_reg <= '0;
                        valid_reg       <= 1'b1;
                        word_cnt_reg    <= word_cnt_reg + 32'd1;
                        blk_pos_reg     <= blk_last ? 5'd0 : blk_pos_reg + 5'd1;
                        last_loaded_reg <= final_word;
                        // A partial final block can end on a message word; stay
                        // in MSG then so only the completion path remains.
                        if (msg_take && last_msg && !final_word)
                            state_reg <= ST_PAD;
                    end else if (xfer) begin
                        valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign valid_o  = valid_reg;
    assign data_out = data_reg;
    assign done_o   = done_reg;
    assign err_o    = err_reg;

endmodule

// File: tb/tb_keccak_msg_tx.sv
// Directed bench for keccak_msg_tx: scoreboard of expected beats checked by a
// negedge monitor. Covers the KECCAK_TX_ERR_EN build when that macro is set.
module tb_keccak_msg_tx;
    import keccak_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_mode = 2'b00;
    logic [29:0] cmd_out_len = '0;
    logic [31:0] cmd_in_len = '0;
    logic        msg_valid_i = 1'b0;
    logic        msg_ready_o;
    logic [63:0] msg_data = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [63:0] data_out;
    logic        done_o;
    logic        err_o;

    always #5 clk = ~clk;

    keccak_msg_tx #(.W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_mode    (cmd_mode),
        .cmd_out_len (cmd_out_len),
        .cmd_in_len  (cmd_in_len),
        .msg_valid_i (msg_valid_i),
        .msg_ready_o (msg_ready_o),
        .msg_data    (msg_data),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_out    (data_out),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    logic [63:0] exp_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          beat_cnt = 0;
    int          msg_hs_cnt = 0;
    bit          saw_msg_ready = 1'b0;
    bit          stall_prev = 1'b0;
    logic [63:0] stall_data = '0;
    bit          frame_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] msg_word(input int i);
        return {32'h0615_5023 + 32'(i), 32'hDEAD_BEEF ^ 32'(i)};
    endfunction

    // Monitor: scoreboard pops on every transfer, stall stability, message handshakes
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(valid_o), 64'd1);
                check("stall_data", data_out, stall_data);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_nonempty", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d", beat_cnt), data_out, e);
                end
                $display("beat %0d data %h", beat_cnt, data_out);
                beat_cnt++;
            end
            stall_prev = valid_o && !ready_i;
            stall_data = data_out;
            if (msg_valid_i && msg_ready_o) msg_hs_cnt++;
            if (msg_ready_o) saw_msg_ready = 1'b1;
        end
    end

    task automatic issue_cmd(input logic [1:0] mode, input logic [29:0] olen, input logic [31:0] ilen);
        int k;
        cmd_mode    = mode;
        cmd_out_len = olen;
        cmd_in_len  = ilen;
        cmd_valid_i = 1'b1;
        k = 0;
        @(negedge clk);
        while (!cmd_ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready", 64'(cmd_ready_o), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] mode, input logic [29:0] olen,
                              input logic [31:0] ilen, input bit toggle, input string name);
        int r, nmsg, ntot, rem;
        logic [63:0] wv, hdr;
        r    = (mode == 2'b00) ? 21 : 17;
        nmsg = int'((longint'(ilen) + 63) / 64);
        ntot = r * int'(longint'(ilen) / longint'(64 * r) + 1);
        rem  = int'(ilen % 32'd64);
        hdr  = {mode, olen, ilen};
        exp_q.push_back(hdr);
        for (int i = 0; i < nmsg; i++) begin
            wv = msg_word(i);
            if (i == nmsg - 1 && rem != 0)
                for (int b = 0; b < 64 - rem; b++) wv[b] = 1'b0;
            exp_q.push_back(wv);
        end
        for (int i = 0; i < ntot - nmsg; i++) exp_q.push_back(64'd0);
        beat_cnt      = 0;
        msg_hs_cnt    = 0;
        saw_msg_ready = 1'b0;
        frame_done    = 1'b0;
        ready_i       = 1'b1;

        issue_cmd(mode, olen, ilen);
        check({name, "_hdr_valid"}, 64'(valid_o), 64'd1);
        check({name, "_hdr_data"}, data_out, hdr);

        fork
            begin
                for (int i = 0; i < nmsg && !frame_done; i++) begin
                    msg_data    = msg_word(i);
                    msg_valid_i = 1'b1;
                    @(negedge clk);
                    while (!msg_ready_o && !frame_done) @(negedge clk);
                    @(posedge clk);
                    #1;
                end
                // Surplus words must be left untouched by the DUT
                msg_data    = 64'hBAD0_BAD1_BAD2_BAD3;
                msg_valid_i = 1'b1;
                while (!frame_done) @(posedge clk);
                msg_valid_i = 1'b0;
            end
            begin
                while (!frame_done) begin
                    @(posedge clk);
                    #1;
                    if (toggle) ready_i = ~ready_i;
                end
                ready_i = 1'b1;
            end
            begin
                int k;
                for (k = 0; k < 3000; k++) begin
                    @(negedge clk);
                    if (done_o) break;
                end
                if (k == 3000) begin
                    total_cnt++;
                    $error("FAIL %s_done_timeout: observed no done_o required done_o within 3000 cycles", name);
                end else begin
                    check({name, "_done_valid"}, 64'(valid_o), 64'd0);
                    check({name, "_done_idle"}, 64'(cmd_ready_o), 64'd1);
                    check({name, "_done_err"}, 64'(err_o), 64'd0);
                    @(negedge clk);
                    check({name, "_done_pulse"}, 64'(done_o), 64'd0);
                end
                frame_done = 1'b1;
            end
        join
        check({name, "_beats"}, 64'(beat_cnt), 64'(ntot + 1));
        check({name, "_msg_taken"}, 64'(msg_hs_cnt), 64'(nmsg));
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        if (nmsg == 0) check({name, "_no_msg_ready"}, 64'(saw_msg_ready), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_data", data_out, 64'd0);
        check("rst_msg_ready", 64'(msg_ready_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("cmd_ready_after_rst", 64'(cmd_ready_o), 64'd1);

        send_frame(MODE_SHAKE256, 30'd256, 32'd32, 1'b0, "shake256_32");
        send_frame(MODE_SHAKE128, 30'd256, 32'd0, 1'b0, "shake128_empty");
        send_frame(MODE_SHAKE256, 30'd512, 32'd1088, 1'b0, "shake256_1088");
        send_frame(MODE_SHAKE256, 30'd256, 32'd32, 1'b1, "shake256_32_stall");
        send_frame(MODE_SHAKE256, 30'd128, 32'd1080, 1'b0, "shake256_1080");
        send_frame(MODE_SHAKE128, 30'd64, 32'd1344, 1'b1, "shake128_1344");

        // Abort a frame after its fifth beat with an asynchronous reset
        exp_q.push_back({MODE_SHAKE256, 30'd256, 32'd1088});
        for (int i = 0; i < 17; i++) exp_q.push_back(64'h0123_4567_89AB_CDEF);
        beat_cnt = 0;
        ready_i  = 1'b1;
        issue_cmd(MODE_SHAKE256, 30'd256, 32'd1088);
        msg_data    = 64'h0123_4567_89AB_CDEF;
        msg_valid_i = 1'b1;
        for (int k = 0; k < 200 && beat_cnt < 5; k++) @(negedge clk);
        check("abort_reached_5_beats", 64'(beat_cnt >= 5), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_valid", 64'(valid_o), 64'd0);
        check("abort_data", data_out, 64'd0);
        check("abort_msg_ready", 64'(msg_ready_o), 64'd0);
        exp_q.delete();
        msg_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("abort_valid_idle", 64'(valid_o), 64'd0);
        send_frame(MODE_SHAKE256, 30'd256, 32'd32, 1'b0, "after_abort");

`ifdef KECCAK_TX_ERR_EN
        issue_cmd(2'b01, 30'd256, 32'd32);
        check("err_pulse", 64'(err_o), 64'd1);
        check("err_no_valid", 64'(valid_o), 64'd0);
        @(posedge clk);
        #1;
        check("err_pulse_end", 64'(err_o), 64'd0);
        check("err_still_no_valid", 64'(valid_o), 64'd0);
        check("err_back_idle", 64'(cmd_ready_o), 64'd1);
`else
        send_frame(2'b01, 30'd512, 32'd32, 1'b0, "mode01_fallback");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/keccak_msg_tx.md
KECCAK_MSG_TX -- requirements
Module: keccak_msg_tx

Interface
REQ-001 SHALL have parameter: W, 64 (keccak_pkg::w), data beat width in bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cmd_valid_i  input  1  command valid.
REQ-005 SHALL have port: cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-006 SHALL have port: cmd_mode  input  2  2'b00 SHAKE128, 2'b10 SHAKE256, others invalid.
REQ-007 SHALL have port: cmd_out_len  input  30  requested output length, bits.
REQ-008 SHALL have port: cmd_in_len  input  32  message length, bits.
REQ-009 SHALL have ports: msg_valid_i input 1, msg_ready_o output 1, msg_data input W; message words, MSB-first, left-aligned.
REQ-010 SHALL have ports: valid_o output 1, ready_i input 1, data_out output W; stream to keccak core input.
REQ-011 SHALL have ports: done_o output 1 (one-cycle pulse after last beat), err_o output 1 (see REQ-027).

Function
REQ-012 SHALL implement FSM IDLE -> HDR -> MSG -> PAD -> IDLE; MSG skipped when message word count is 0.
REQ-013 SHALL assert cmd_ready_o only in IDLE; command fields latched on cmd handshake.
REQ-014 SHALL present header {cmd_mode, cmd_out_len, cmd_in_len} on data_out with valid_o high the cycle after command acceptance.
REQ-015 SHALL compute message words = ceil(in_len/64) and total data words = RATE_WORDS x (floor(in_len/rate_bits) + 1); SHAKE128 rate 21 words/1344 bits, SHAKE256 17 words/1088 bits.
REQ-016 SHALL in MSG forward msg_data to data_out; msg_ready_o = MSG state and output register free or being drained.
REQ-017 SHALL zero bits [63-r:0] of the final message word when r = in_len mod 64 is non-zero.
REQ-018 SHALL in PAD emit zero words until total data words reached; msg_ready_o low outside MSG.
REQ-019 SHALL hold data_out and valid_o stable while valid_o=1 and ready_i=0; a beat transfers when valid_o and ready_i are both high.
REQ-020 SHALL sustain one beat per cycle when ready_i and msg_valid_i stay high.
REQ-021 SHALL pulse done_o the cycle after the final data beat transfers and return to IDLE that same cycle.
REQ-022 SHALL ignore msg_valid_i outside MSG; extra words are not consumed.
REQ-023 SHALL use a 32-bit word counter; no wrap for in_len <= 2^32-1.

Reset
REQ-024 SHALL on rst low immediately force IDLE, valid_o=0, data_out=0, msg_ready_o=0, done_o=0, err_o=0, counters 0.
REQ-025 SHALL assert cmd_ready_o the first clock edge after rst deasserts; reset mid-transfer abandons the frame, no partial completion.

Configuration
REQ-026 SHALL support macro KECCAK_TX_ERR_EN.
REQ-027 SHALL with KECCAK_TX_ERR_EN: invalid cmd_mode accepted, dropped, err_o pulses one cycle, no output beats; without: err_o tied 0, invalid modes use SHAKE256 rate, header carries mode unchanged.

Structure
REQ-028 SHALL place mode encodings, RATE_WORDS per mode, header field offsets and the state enum in keccak_pkg.
REQ-029 SHALL be a single module; no sub-module.

Verification
REQ-030 SHAKE256, out_len 256, in_len 32, msg 0x06155023_DEADBEEF -> 0x8000010000000020, 0x0615502300000000, 16 zero words; 18 beats, then done_o.
REQ-031 SHAKE128, in_len 0 -> header then 21 zero words; msg_ready_o never high.
REQ-032 SHAKE256, in_len 1088, 17 words -> header, 17 message words, 17 zero words (35 beats).
REQ-033 REQ-030 with ready_i toggling 1/0 each cycle -> identical sequence, data_out stable on every stall.
REQ-034 rst low after 5th beat -> valid_o 0 asynchronously; cmd_ready_o 1 after release; next command produces correct full frame.
REQ-035 KECCAK_TX_ERR_EN, cmd_mode 2'b01 -> err_o one pulse, valid_o stays 0, back in IDLE.
